branch_target_buffer: RTL and testbench

2-way set-associative branch target buffer that feeds the fetch stage its next-PC prediction. Fetch presents its current PC every cycle and receives a same-cycle hit/miss and predicted target. Execute writes each resolved control-flow instruction back into the buffer, which allocates, retrains or evicts entries.

---
 rtl/branch_target_buffer.sv | 120 ++++++++++++
 tb/tb_branch_target_buffer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer: same-cycle lookup for fetch, clocked training from execute.
// Optional BTB_2BIT_COUNTER_EN adds a 2-bit saturating direction counter per entry.
`timescale 1ns/1ps
module branch_target_buffer #(
  parameter int SETS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        btb_miss,
  output logic [31:0] btb_rdata,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 30 - IDX;

  logic [1:0]      valid_r  [SETS];
  logic [TAGW-1:0] tag_r    [SETS][2];
  logic [31:0]     target_r [SETS][2];
  logic [SETS-1:0] lru_r;
`ifdef BTB_2BIT_COUNTER_EN
  logic [1:0]      ctr_r    [SETS][2];

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) return 2'b11;
    else return c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) return 2'b00;
    else return c - 2'b01;
  endfunction
`endif

  logic [IDX-1:0]  f_idx_s;
  logic [TAGW-1:0] f_tag_s;
  logic [1:0]      f_hit_s;
  logic            f_way_s;
  logic            f_pred_s;

  logic [IDX-1:0]  u_idx_s;
  logic [TAGW-1:0] u_tag_s;
  logic [1:0]      u_hit_s;
  logic            u_hit_any_s;
  logic            u_way_s;

  logic            unused_pc_bits_s;
  assign unused_pc_bits_s = ^{fetch_pc[1:0], update_pc[1:0]};

  // Fetch lookup: pure function of fetch_pc and stored state.
  always_comb begin
    f_idx_s    = fetch_pc[IDX+1:2];
    f_tag_s    = fetch_pc[31:IDX+2];
    f_hit_s[0] = valid_r[f_idx_s][0] && (tag_r[f_idx_s][1'b0] == f_tag_s);
    f_hit_s[1] = valid_r[f_idx_s][1] && (tag_r[f_idx_s][1'b1] == f_tag_s);
    f_way_s    = f_hit_s[1];
`ifdef BTB_2BIT_COUNTER_EN
    f_pred_s   = (|f_hit_s) && ctr_r[f_idx_s][f_way_s][1];
`else
    f_pred_s   = |f_hit_s;
`endif
    btb_miss   = ~f_pred_s;
    if (f_pred_s) btb_rdata = target_r[f_idx_s][f_way_s];
    else          btb_rdata = 32'h0000_0000;
  end

  // Update way selection: hit way, else first invalid way, else the LRU victim.
  always_comb begin
    u_idx_s     = update_pc[IDX+1:2];
    u_tag_s     = update_pc[31:IDX+2];
    u_hit_s[0]  = valid_r[u_idx_s][0] && (tag_r[u_idx_s][1'b0] == u_tag_s);
    u_hit_s[1]  = valid_r[u_idx_s][1] && (tag_r[u_idx_s][1'b1] == u_tag_s);
    u_hit_any_s = |u_hit_s;
    if (u_hit_any_s)                 u_way_s = u_hit_s[1];
    else if (!valid_r[u_idx_s][0])   u_way_s = 1'b0;
    else if (!valid_r[u_idx_s][1])   u_way_s = 1'b1;
    else                             u_way_s = lru_r[u_idx_s];
  end

  // Control state: valid, LRU and counters; reset discards any concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= 2'b00;
`ifdef BTB_2BIT_COUNTER_EN
        ctr_r[s][0] <= 2'b00;
        ctr_r[s][1] <= 2'b00;
`endif
      end
      lru_r <= {SETS{1'b0}};
    end else if (update_valid) begin
      if (update_taken) begin
        valid_r[u_idx_s][u_way_s] <= 1'b1;
        lru_r[u_idx_s]            <= ~u_way_s;
`ifdef BTB_2BIT_COUNTER_EN
        if (u_hit_any_s) ctr_r[u_idx_s][u_way_s] <= ctr_inc(ctr_r[u_idx_s][u_way_s]);
        else             ctr_r[u_idx_s][u_way_s] <= 2'b10;
`endif
      end else if (u_hit_any_s) begin
`ifdef BTB_2BIT_COUNTER_EN
        ctr_r[u_idx_s][u_way_s] <= ctr_dec(ctr_r[u_idx_s][u_way_s]);
`else
        valid_r[u_idx_s][u_way_s] <= 1'b0;
`endif
      end
    end
  end

  // Payload: tag and target carry no reset, they are qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst && update_valid && update_taken) begin
      tag_r[u_idx_s][u_way_s]    <= u_tag_s;
      target_r[u_idx_s][u_way_s] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus pushes expected lookups, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        btb_miss;
  logic [31:0] btb_rdata;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;

  typedef struct {
    logic        miss;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic chk_en = 1'b0;
  int   checks = 0;
  int   fails  = 0;

`ifdef BTB_2BIT_COUNTER_EN
  localparam logic        C7_MISS = 1'b0;
  localparam logic [31:0] C7_DATA = 32'h4000_0100;
`else
  localparam logic        C7_MISS = 1'b1;
  localparam logic [31:0] C7_DATA = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  branch_target_buffer #(.SETS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_pc     (fetch_pc),
    .btb_miss     (btb_miss),
    .btb_rdata    (btb_rdata),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_target(update_target),
    .update_taken (update_taken)
  );

  // Monitor: compare the lookup presented this cycle against the oldest expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      checks <= checks + 1;
      if (sb.size() == 0) begin
        fails <= fails + 1;
        $display("FAIL scoreboard_empty: got miss=%0b rdata=%h, no expectation queued", btb_miss, btb_rdata);
      end else begin
        if (btb_miss !== sb[0].miss || btb_rdata !== sb[0].data) begin
          fails <= fails + 1;
          $display("FAIL %s: got miss=%0b rdata=%h, expected miss=%0b rdata=%h",
                   sb[0].name, btb_miss, btb_rdata, sb[0].miss, sb[0].data);
        end
        sb.delete(0);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic ut,
                      input logic chk, input logic emiss, input logic [31:0] edata, input string nm);
    @(posedge clk);
    #1;
    rst           = r;
    fetch_pc      = fpc;
    update_valid  = uv;
    update_pc     = upc;
    update_target = utgt;
    update_taken  = ut;
    chk_en        = chk;
    if (chk) sb.push_back('{miss: emiss, data: edata, name: nm});
  endtask

  initial begin
    rst = 1'b1; fetch_pc = 32'h0; update_valid = 1'b0;
    update_pc = 32'h0; update_target = 32'h0; update_taken = 1'b0;
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "");
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "");

    // Reset state, first allocation and LRU eviction in set 4.
    step(1'b0, 32'h4000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "reset_miss");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b1, 1'b1, 1'b1, 32'h0, "pre_alloc_miss");
    step(1'b0, 32'h4000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0100, "alloc_hit");
    step(1'b0, 32'h4000_0030, 1'b1, 32'h4000_0030, 32'h4000_0300, 1'b1, 1'b1, 1'b1, 32'h0, "other_tag_miss");
    step(1'b0, 32'h4000_0030, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b1, 1'b1, 1'b0, 32'h4000_0300, "way1_hit");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0050, 32'h4000_0500, 1'b1, 1'b1, 1'b0, 32'h4000_0100, "way0_hit");
    step(1'b0, 32'h4000_0030, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "evicted_miss");
    step(1'b0, 32'h4000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0100, "retained_hit");
    step(1'b0, 32'h4000_0050, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0500, "new_hit");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0070, 32'h4000_0700, 1'b0, 1'b1, 1'b0, 32'h4000_0100, "nt_miss_hit10");
    step(1'b0, 32'h4000_0050, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0500, "nt_miss_hit50");
    step(1'b0, 32'h4000_0070, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "nt_miss_no_alloc");

    // Direction training on a fresh entry.
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b1, 1'b1, 1'b1, 32'h0, "c1_after_reset");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b0, 1'b1, 1'b0, 32'h4000_0100, "c2_alloc_hit");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b1, 1'b1, 1'b1, 32'h0, "c3_one_nt_miss");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b1, 1'b1, 1'b0, 32'h4000_0100, "c4_retaken_hit");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b1, 1'b1, 1'b0, 32'h4000_0100, "c5_hit");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b0, 1'b1, 1'b0, 32'h4000_0100, "c6_saturated_hit");
    step(1'b0, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'h4000_0100, 1'b0, 1'b1, C7_MISS, C7_DATA, "c7_after_nt");
    step(1'b0, 32'h4000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "c8_two_nt_miss");

    // Same-cycle lookup sees pre-update contents.
    step(1'b0, 32'h4000_0020, 1'b1, 32'h4000_0020, 32'h4000_0400, 1'b1, 1'b1, 1'b1, 32'h0, "same_cycle_miss");
    step(1'b0, 32'h4000_0020, 1'b1, 32'h4000_0004, 32'h4000_0040, 1'b1, 1'b1, 1'b0, 32'h4000_0400, "next_cycle_hit");
    step(1'b0, 32'h4000_0004, 1'b1, 32'h4000_0008, 32'h4000_0080, 1'b1, 1'b1, 1'b0, 32'h4000_0040, "fill_hit04");
    step(1'b0, 32'h4000_0008, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0080, "fill_hit08");

    // Reset with a concurrent update discards everything.
    step(1'b1, 32'h0, 1'b1, 32'h4000_000C, 32'h4000_00C0, 1'b1, 1'b0, 1'b1, 32'h0, "");
    step(1'b0, 32'h4000_000C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "rst_concurrent_miss");
    step(1'b0, 32'h4000_0020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "rst_miss20");
    step(1'b0, 32'h4000_0004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "rst_miss04");
    step(1'b0, 32'h4000_0008, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "rst_miss08");
    step(1'b0, 32'h4000_0010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "rst_miss10");

    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "");
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
